// File: rtl/mul_final_add.sv
// Final carry-propagate add and word select for the multiply unit: S1 captures the tree vectors, S2 holds the result.
// Define MUL_SPLIT_ADD_EN to split the 66-bit add across both stages (low 33 bits in S1, high 33 bits in S2).
module mul_final_add #(
    parameter int WORD_WIDTH            = 32,
    parameter int SIGNED_WORD_WIDTH     = WORD_WIDTH + 1,
    parameter int PARTIAL_PRODUCT_WIDTH = 2 * SIGNED_WORD_WIDTH,
    parameter int TAG_WIDTH             = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PARTIAL_PRODUCT_WIDTH-1:0] mul_add_a,
    input  logic [PARTIAL_PRODUCT_WIDTH-1:0] mul_add_b,
    input  logic [1:0]                       mul_op,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH-1:0]            out_result,
    output logic [TAG_WIDTH-1:0]             out_tag
);

    localparam int PW = PARTIAL_PRODUCT_WIDTH;
    localparam int LW = SIGNED_WORD_WIDTH;
    localparam int HW = PW - LW;

    function automatic logic [WORD_WIDTH-1:0] select_word(input logic [PW-1:0] p, input logic [1:0] op);
        return (op == 2'b00) ? p[WORD_WIDTH-1:0] : p[2*WORD_WIDTH-1:WORD_WIDTH];
    endfunction

    logic                  vld_p1_q, vld_p2_q;
    logic [1:0]            op_p1_q;
    logic [TAG_WIDTH-1:0]  tag_p1_q, tag_p2_q;
    logic [WORD_WIDTH-1:0] result_p2_q, result_d;
    logic [PW-1:0]         sum_d;
    logic                  s1_adv, s2_adv, accept;

    assign s2_adv   = !vld_p2_q || out_ready;
    assign s1_adv   = vld_p1_q && s2_adv;
    assign in_ready = !vld_p1_q || s2_adv;
    assign accept   = in_valid && in_ready;

`ifdef MUL_SPLIT_ADD_EN
    logic [LW-1:0] lo_p1_q;
    logic          cy_p1_q;
    logic [HW-1:0] ahi_p1_q, bhi_p1_q;
    logic [LW:0]   lo_d;
    logic [HW-1:0] hi_d;

    assign lo_d  = {1'b0, mul_add_a[LW-1:0]} + {1'b0, mul_add_b[LW-1:0]};
    assign hi_d  = ahi_p1_q + bhi_p1_q + {{(HW-1){1'b0}}, cy_p1_q};
    assign sum_d = {hi_d, lo_p1_q};

    // ---- S1: low half add, high halves captured ----
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_p1_q  <= '0;
            cy_p1_q  <= 1'b0;
            ahi_p1_q <= '0;
            bhi_p1_q <= '0;
        end else if (accept && !flush) begin
            lo_p1_q  <= lo_d[LW-1:0];
            cy_p1_q  <= lo_d[LW];
            ahi_p1_q <= mul_add_a[PW-1:LW];
            bhi_p1_q <= mul_add_b[PW-1:LW];
        end
    end
`else
    logic [PW-1:0] a_p1_q, b_p1_q;

    assign sum_d = a_p1_q + b_p1_q;

    // ---- S1: raw redundant operands captured ----
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p1_q <= '0;
            b_p1_q <= '0;
        end else if (accept && !flush) begin
            a_p1_q <= mul_add_a;
            b_p1_q <= mul_add_b;
        end
    end
`endif

    assign result_d = select_word(sum_d, op_p1_q);

    // ---- S1 control, op and tag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            op_p1_q  <= '0;
            tag_p1_q <= '0;
        end else if (flush) begin
            vld_p1_q <= 1'b0;
        end else if (accept) begin
            vld_p1_q <= 1'b1;
            op_p1_q  <= mul_op;
            tag_p1_q <= in_tag;
        end else if (s1_adv) begin
            vld_p1_q <= 1'b0;
        end
    end

    // ---- S2: result register, drives the output port directly ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q    <= 1'b0;
            result_p2_q <= '0;
            tag_p2_q    <= '0;
        end else if (flush) begin
            vld_p2_q <= 1'b0;
        end else if (s2_adv) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                result_p2_q <= result_d;
                tag_p2_q    <= tag_p1_q;
            end
        end
    end

    assign out_valid  = vld_p2_q;
    assign out_result = result_p2_q;
    assign out_tag    = tag_p2_q;

endmodule
